adder_tree_accum: RTL and testbench
===================================

# adder_tree_accum

Parametrised, pipelined multi-operand adder tree with frame accumulation and saturation, for neuron dendritic summation. Each accepted beat carries N_IN synaptic operands. A registered binary tree reduces them, and an accumulator sums the tree results over a frame delimited by `in_last`. The block supersedes the fixed 8-input ripple chain. It adds a parametrised width and operand count, signed or unsigned mode, valid/ready flow control and saturation.

## Interface
- N_IN, 8: operands per beat; power of two, 2..16; L = log2(N_IN) tree levels.
- W, 8: operand width.
- ACC_W, 16: accumulator/result width; must satisfy ACC_W >= W+L.
- SIGNED, 0: 0 = unsigned operands and result; 1 = two's complement.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush of pipeline, accumulator and output register.
- in_valid  in  1  beat present.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  N_IN*W  operand k at bits [k*W +: W].
- in_last  in  1  beat closes the current frame.
- out_valid  out  1  frame result held.
- out_ready  in  1  consumer accepts result.
- out_sum  out  ACC_W  saturated frame sum.
- out_sat  out  1  any clamp occurred during this frame.

## Operation
- Tree: level j registers N_IN/2^(j+1) sums of width W+j+1, each sign- or zero-extended per SIGNED. There are L register levels. A valid bit and a last bit travel with each level.
- Accumulator stage:
  - When a valid tree result arrives, compute acc_next = (first ? 0 : acc) + tree_out at ACC_W+1 bits.
  - Clamp to the representable range: unsigned [0, 2^ACC_W-1]; signed [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Saturation is sticky: the running value after a clamp is the clamped value, and sat_acc is ORed.
- `first` is set by reset, by clear, and after each last beat. It is cleared by the first valid beat of a frame.
- Last beat at the accumulator stage:
  - out_sum is loaded with the clamped acc_next.
  - out_sat is loaded with sat_acc OR'd with this beat's clamp.
  - out_valid is set, acc and sat_acc are zeroed, and first is set.
- Output: out_valid stays high with out_sum and out_sat stable until out_valid && out_ready. It then drops the next cycle, unless a new result loads that same cycle.
- Flow control: stall = out_valid && !out_ready. in_ready = !stall (combinational). While stalled, every tree level and the accumulator hold their contents.
- Frames may span any number of beats ≥1. Beats with in_valid low are bubbles and do not affect the sum.
- clear overrides stall and in-flight data:
  - All level valids, acc, sat_acc and out_valid go to 0; first goes to 1.
  - A beat presented in the same cycle as clear is discarded.
- Reset values: out_valid=0, out_sum=0, out_sat=0, in_ready=1. All pipeline valids, acc and sat_acc are 0; first=1.

## Timing
- Latency: the last beat accepted at edge t gives out_valid high after edge t+L+1 (N_IN=8: 4 cycles), absent stalls.
- Throughput: one beat per cycle; back-to-back single-beat frames give one result per cycle when out_ready=1.
- If out_valid && out_ready and a new last arrives at the accumulator in the same cycle, the new result loads with no bubble.
- Stalls add exactly one cycle of latency per stalled cycle. No beat is lost, duplicated or reordered.
- rst_n assertion mid-frame clears all state immediately, asynchronously; partial frames are discarded.

## Test plan
- N_IN=8, W=8, ACC_W=16, SIGNED=0; one beat, all operands 255, in_last=1 -> out_valid 4 cycles later, out_sum=2040, out_sat=0.
- Three beats with operands 1..8 (36 per beat), last on the third, one bubble between beats 1 and 2 -> out_sum=108, out_sat=0.
- ACC_W=12; three beats of all-255 (6120 total) -> out_sum=4095, out_sat=1. The following one-beat frame summing 36 -> out_sum=36, out_sat=0.
- SIGNED=1, ACC_W=11; a frame of two beats of all -128 -> out_sum=-1024 (clamped from -2048), out_sat=1. A beat of all +127 -> out_sum=1016, out_sat=0.
- Stream of one-beat frames with sums 10, 20, 30, ... while out_ready is held low 5 cycles -> in_ready low exactly while out_valid && !out_ready. Results arrive in order, none lost or duplicated.
- clear pulsed after beat 2 of a 4-beat frame, then a fresh one-beat frame summing 36 -> no result from the aborted frame; out_sum=36. Repeat with rst_n low mid-frame -> all outputs 0 during reset.

Source files
------------

// File: rtl/adder_tree_accum.sv
// adder_tree_accum
//   Pipelined multi-operand adder tree with frame accumulation and saturation,
//   used for dendritic summation of N_IN synaptic operands per beat.
//
//   Parameters
//     N_IN   operands per beat (power of two, 2..16), L = log2(N_IN) tree levels
//     W      operand width
//     ACC_W  accumulator / result width (ACC_W >= W + L)
//     SIGNED 0 = unsigned operands and result, 1 = two's complement
//
//   Ports
//     clk, rst_n            clock (rising edge), asynchronous active-low reset
//     clear                 synchronous flush of pipeline, accumulator, output
//     in_valid/in_ready     beat handshake; in_data operand k at [k*W +: W]
//     in_last               beat closes the current frame
//     out_valid/out_ready   result handshake
//     out_sum, out_sat      saturated frame sum, sticky clamp flag for the frame
module adder_tree_accum #(
  parameter int N_IN   = 8,
  parameter int W      = 8,
  parameter int ACC_W  = 16,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN*W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_sat
);

  localparam int L  = $clog2(N_IN);
  localparam int TW = W + L;   // width of the final tree sum

  // A held result that nobody takes freezes the whole pipe.
  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Beat register: the acceptance point of a beat; isolates in_data fanout
  // from the first adder level.
  logic [N_IN*W-1:0] beat_data;
  logic              beat_vld;
  logic              beat_lst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_data <= '0;
      beat_vld  <= 1'b0;
      beat_lst  <= 1'b0;
    end else if (clear) begin
      beat_vld  <= 1'b0;
      beat_lst  <= 1'b0;
    end else if (!stall) begin
      beat_data <= in_data;
      beat_vld  <= in_valid;
      beat_lst  <= in_last;
    end
  end

  // Registered binary tree. Level gi holds N_IN>>(gi+1) sums of W+gi+1 bits;
  // each operand is widened by one bit (sign or zero) before adding.
  genvar gi, gk;
  generate
    for (gi = 0; gi < L; gi++) begin : lvl
      localparam int NS = N_IN >> (gi + 1);
      localparam int SW = W + gi + 1;

      logic src_vld, src_lst;
      logic vld, lst;

      if (gi == 0) begin : from_beat
        assign src_vld = beat_vld;
        assign src_lst = beat_lst;
      end else begin : from_lvl
        assign src_vld = lvl[gi-1].vld;
        assign src_lst = lvl[gi-1].lst;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld <= 1'b0;
          lst <= 1'b0;
        end else if (clear) begin
          vld <= 1'b0;
          lst <= 1'b0;
        end else if (!stall) begin
          vld <= src_vld;
          lst <= src_lst;
        end
      end

      for (gk = 0; gk < NS; gk++) begin : node
        logic [SW-2:0] a, b;
        logic          ea, eb;
        logic [SW-1:0] sum;

        if (gi == 0) begin : src_in
          assign a = beat_data[(2*gk)*W +: W];
          assign b = beat_data[(2*gk+1)*W +: W];
        end else begin : src_prev
          assign a = lvl[gi-1].node[2*gk].sum;
          assign b = lvl[gi-1].node[2*gk+1].sum;
        end

        assign ea = (SIGNED != 0) && a[SW-2];
        assign eb = (SIGNED != 0) && b[SW-2];

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            sum <= '0;
          end else if (!stall) begin
            sum <= {ea, a} + {eb, b};
          end
        end
      end
    end
  endgenerate

  logic [TW-1:0] tree_sum;
  logic          tree_vld, tree_lst;
  assign tree_sum = lvl[L-1].node[0].sum;
  assign tree_vld = lvl[L-1].vld;
  assign tree_lst = lvl[L-1].lst;

  // Accumulator state
  logic [ACC_W-1:0] acc;
  logic             sat_acc;
  logic             first;

  // One guard bit above ACC_W is enough: both addends already fit ACC_W bits.
  logic [ACC_W:0]   tree_ext, acc_ext, acc_next;
  logic [ACC_W-1:0] acc_clamp;
  logic             clamp;

  always_comb begin
    tree_ext  = '0;
    acc_ext   = '0;
    acc_next  = '0;
    acc_clamp = '0;
    clamp     = 1'b0;

    if (SIGNED != 0) begin
      tree_ext = {{(ACC_W+1-TW){tree_sum[TW-1]}}, tree_sum};
      acc_ext  = {acc[ACC_W-1], acc};
    end else begin
      tree_ext = {{(ACC_W+1-TW){1'b0}}, tree_sum};
      acc_ext  = {1'b0, acc};
    end

    acc_next  = (first ? '0 : acc_ext) + tree_ext;
    acc_clamp = acc_next[ACC_W-1:0];

    if (SIGNED != 0) begin
      // Overflow shows as the guard bit disagreeing with the result sign.
      if (acc_next[ACC_W] != acc_next[ACC_W-1]) begin
        clamp     = 1'b1;
        acc_clamp = acc_next[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else if (acc_next[ACC_W]) begin
      clamp     = 1'b1;
      acc_clamp = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      sat_acc   <= 1'b0;
      first     <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      sat_acc   <= 1'b0;
      first     <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // A new result loading in the handshake cycle overrides the drop above.
      if (!stall && tree_vld) begin
        if (tree_lst) begin
          out_sum   <= acc_clamp;
          out_sat   <= sat_acc | clamp;
          out_valid <= 1'b1;
          acc       <= '0;
          sat_acc   <= 1'b0;
          first     <= 1'b1;
        end else begin
          acc       <= acc_clamp;
          sat_acc   <= sat_acc | clamp;
          first     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_accum.sv
// tb_adder_tree_accum
//   Directed bench for adder_tree_accum. Three instances share stimulus:
//   u0 (unsigned, ACC_W=16), u1 (unsigned, ACC_W=12), u2 (signed, ACC_W=11).
//   Results are collected per instance at the falling edge and compared
//   against hand-computed values.
`timescale 1ns/1ps
module tb_adder_tree_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] in_data = '0;

  logic        rdy0, rdy1, rdy2;
  logic        ov0, ov1, ov2;
  logic        sat0, sat1, sat2;
  logic [15:0] sum0;
  logic [11:0] sum1;
  logic [10:0] sum2;

  localparam logic [63:0] SEQ18 = 64'h0807060504030201; // operands 1..8, sum 36

  always #5 clk = ~clk;

  adder_tree_accum #(.N_IN(8), .W(8), .ACC_W(16), .SIGNED(0)) u0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(rdy0), .in_data(in_data), .in_last(in_last),
    .out_valid(ov0), .out_ready(out_ready), .out_sum(sum0), .out_sat(sat0));

  adder_tree_accum #(.N_IN(8), .W(8), .ACC_W(12), .SIGNED(0)) u1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(rdy1), .in_data(in_data), .in_last(in_last),
    .out_valid(ov1), .out_ready(out_ready), .out_sum(sum1), .out_sat(sat1));

  adder_tree_accum #(.N_IN(8), .W(8), .ACC_W(11), .SIGNED(1)) u2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(rdy2), .in_data(in_data), .in_last(in_last),
    .out_valid(ov2), .out_ready(out_ready), .out_sum(sum2), .out_sat(sat2));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int stall_cnt = 0;
  logic stream_on = 1'b0;

  int q0_sum[$], q0_sat[$], q0_cyc[$];
  int q1_sum[$], q1_sat[$];
  int q2_sum[$], q2_sat[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Result collector: a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ov0 && out_ready) begin
        q0_sum.push_back(int'(sum0)); q0_sat.push_back(int'(sat0)); q0_cyc.push_back(cyc);
        $display("u0 result sum=%0d sat=%0d cyc=%0d", sum0, sat0, cyc);
      end
      if (ov1 && out_ready) begin
        q1_sum.push_back(int'(sum1)); q1_sat.push_back(int'(sat1));
        $display("u1 result sum=%0d sat=%0d", sum1, sat1);
      end
      if (ov2 && out_ready) begin
        q2_sum.push_back(int'(sum2)); q2_sat.push_back(int'(sat2));
        $display("u2 result sum=%0d (signed %0d) sat=%0d", sum2, $signed(sum2), sat2);
      end
      if (stream_on) begin
        chk("rdy_vs_stall", rdy0, !(ov0 && !out_ready));
        if (!rdy0) stall_cnt++;
      end
    end
  end

  function automatic logic [63:0] fill(input logic [7:0] v);
    return {8{v}};
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0:       return q0_sum.size();
      1:       return q1_sum.size();
      default: return q2_sum.size();
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic flush();
    q0_sum.delete(); q0_sat.delete(); q0_cyc.delete();
    q1_sum.delete(); q1_sat.delete();
    q2_sum.delete(); q2_sat.delete();
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [63:0] d, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    @(negedge clk);
    while (!rdy0 && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) chk("send_accept", rdy0, 1);
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0; in_last = 1'b0;
    $display("beat data=%h last=%0d accepted cyc=%0d", d, last, acc_cyc);
  endtask

  task automatic wait_res(input int d, input string tag, output int s, output int st, output int c);
    int n;
    n = 0; s = 0; st = 0; c = 0;
    while (qsize(d) == 0 && n < 100) begin @(negedge clk); n++; end
    chk({tag, "_arrive"}, qsize(d) != 0, 1);
    if (qsize(d) != 0) begin
      case (d)
        0: begin s = q0_sum.pop_front(); st = q0_sat.pop_front(); c = q0_cyc.pop_front(); end
        1: begin s = q1_sum.pop_front(); st = q1_sat.pop_front(); end
        default: begin s = q2_sum.pop_front(); st = q2_sat.pop_front(); end
      endcase
    end
  endtask

  initial begin
    int s, st, c, n;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", ov0, 0);
    chk("rst_out_sum", sum0, 0);
    chk("rst_out_sat", sat0, 0);
    chk("rst_in_ready", rdy0, 1);
    rst_n = 1'b1;
    tick();
    chk("post_rst_out_valid", ov0, 0);

    // T1: one beat of all 255, latency and value
    send(fill(8'hFF), 1'b1);
    wait_res(0, "t1", s, st, c);
    chk("t1_sum", s, 2040);
    chk("t1_sat", st, 0);
    chk("t1_latency", c - acc_cyc, 4);
    tick();
    chk("t1_valid_drop", ov0, 0);
    idle(10); flush();

    // T2: three beats of 1..8 with a bubble between beats 1 and 2
    send(SEQ18, 1'b0);
    tick();
    send(SEQ18, 1'b0);
    send(SEQ18, 1'b1);
    wait_res(0, "t2", s, st, c);
    chk("t2_sum", s, 108);
    chk("t2_sat", st, 0);
    idle(10); flush();

    // T3: unsigned saturation at ACC_W=12, then a clean frame
    send(fill(8'hFF), 1'b0);
    send(fill(8'hFF), 1'b0);
    send(fill(8'hFF), 1'b1);
    wait_res(1, "t3a", s, st, c);
    chk("t3a_sum", s, 4095);
    chk("t3a_sat", st, 1);
    wait_res(0, "t3w", s, st, c);
    chk("t3w_sum_wide", s, 6120);
    chk("t3w_sat_wide", st, 0);
    tick();
    send(SEQ18, 1'b1);
    wait_res(1, "t3b", s, st, c);
    chk("t3b_sum", s, 36);
    chk("t3b_sat", st, 0);
    idle(10); flush();

    // T4: signed saturation at ACC_W=11 (-2048 clamps to -1024 = 11'h400)
    send(fill(8'h80), 1'b0);
    send(fill(8'h80), 1'b1);
    wait_res(2, "t4a", s, st, c);
    chk("t4a_sum", s, 32'h400);
    chk("t4a_sat", st, 1);
    tick();
    send(fill(8'h7F), 1'b1);
    wait_res(2, "t4b", s, st, c);
    chk("t4b_sum", s, 1016);
    chk("t4b_sat", st, 0);
    idle(10); flush();

    // T5: stream of one-beat frames 10,20,...,80 with out_ready low 5 cycles
    stall_cnt = 0;
    stream_on = 1'b1;
    fork
      begin
        for (int i = 1; i <= 8; i++) begin
          logic [7:0] v;
          v = 8'(10 * i);
          send({56'h0, v}, 1'b1);
        end
      end
      begin
        int m;
        m = 0;
        while (!ov0 && m < 100) begin @(negedge clk); m++; end
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
      end
    join
    idle(10);
    stream_on = 1'b0;
    chk("t5_stall_cycles", stall_cnt, 5);
    chk("t5_count", q0_sum.size(), 8);
    for (int i = 1; i <= 8; i++) begin
      wait_res(0, "t5", s, st, c);
      chk("t5_order", s, 10 * i);
    end
    flush();

    // T6: clear after beat 2 of a frame; beat presented with clear is dropped
    send(fill(8'h01), 1'b0);
    send(fill(8'h01), 1'b0);
    clear = 1'b1; in_valid = 1'b1; in_data = fill(8'h01); in_last = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    idle(10);
    chk("t6_no_result", q0_sum.size(), 0);
    chk("t6_out_valid", ov0, 0);
    send(SEQ18, 1'b1);
    wait_res(0, "t6", s, st, c);
    chk("t6_sum", s, 36);
    idle(10);
    chk("t6_single", q0_sum.size(), 0);
    flush();

    // T7: asynchronous reset with a held result and a partial frame in flight
    out_ready = 1'b0;
    send(SEQ18, 1'b1);
    send(fill(8'h01), 1'b0);
    n = 0;
    while (!ov0 && n < 100) begin @(negedge clk); n++; end
    #2;
    chk("t7_held_valid", ov0, 1);
    chk("t7_held_sum", sum0, 36);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", ov0, 0);
    chk("t7_rst_sum", sum0, 0);
    chk("t7_rst_sat", sat0, 0);
    chk("t7_rst_ready", rdy0, 1);
    chk("t7_rst_sum_u1", sum1, 0);
    tick(); tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    flush();
    tick();
    send(SEQ18, 1'b1);
    wait_res(0, "t7", s, st, c);
    chk("t7_sum", s, 36);
    chk("t7_sat", st, 0);
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
